// File: rtl/dp_pkg.sv
// dp_pkg: shared codes and FSM encoding for datapath_seq.
// Also provides the register-index width helper used by the datapath and its register file.
package dp_pkg;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;
  localparam logic [1:0] SH_NONE  = 2'b00;
  localparam logic [1:0] SH_LSL   = 2'b01;
  localparam logic [1:0] SH_LSR   = 2'b10;
  localparam logic [1:0] SH_ASR   = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_LD_A, S_LD_B, S_EXEC, S_WB} state_e;
  function automatic int ra_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction
endpackage

// File: rtl/regfile_p.sv
// regfile_p: register file with one synchronous write port and two asynchronous read ports.
// Every entry clears on reset.
module regfile_p
  import dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RA = ra_w(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [RA-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RA-1:0]    raddr_a_i,
  input  logic [RA-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);
  logic [WIDTH-1:0] mem_q [NREGS];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: register file, A/B/C registers, shifter, ALU and flags driven by an internal sequencer.
// One start runs LD_A -> LD_B -> EXEC -> WB; ext_we writes the register file directly while idle.
module datapath_seq
  import dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 5,
  localparam int RA = ra_w(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ext_we,
  input  logic [RA-1:0]    rd,
  input  logic [RA-1:0]    rn,
  input  logic [RA-1:0]    rm,
  input  logic [1:0]       shift,
  input  logic [1:0]       alu_op,
  input  logic             a_zero,
  input  logic             use_imm,
  input  logic             cmp,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] ext_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             v
);
  state_e state_q, state_d;
  logic [RA-1:0] rd_q, rn_q, rm_q;
  logic [1:0] shift_q, alu_op_q;
  logic a_zero_q, use_imm_q, cmp_q, ext_done_q;
  logic [IMM_W-1:0] imm_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, c_d, a_in, b_sh, b_in, sum, diff, rdata_a, rdata_b;
  logic z_q, n_q, v_q, v_d, idle, rf_we;
  assign idle = state_q == S_IDLE;
  // ext_we has priority over start in IDLE, so the write uses the live rd/ext_in
  assign rf_we = (idle && ext_we) || (state_q == S_WB && !cmp_q);
  regfile_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (idle ? rd : rd_q),
    .wdata_i   (idle ? ext_in : c_q),
    .raddr_a_i (rn_q),
    .raddr_b_i (rm_q),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (start && !ext_we) ? S_LD_A : S_IDLE;
      S_LD_A:  state_d = S_LD_B;
      S_LD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
    busy = !idle;
    done = state_q == S_WB || ext_done_q;
  end
  always_comb begin
    a_in = a_zero_q ? '0 : a_q;
    b_sh = shift_q == SH_LSL ? {b_q[WIDTH-2:0], 1'b0} :
           shift_q == SH_LSR ? {1'b0, b_q[WIDTH-1:1]} :
           shift_q == SH_ASR ? {b_q[WIDTH-1], b_q[WIDTH-1:1]} : b_q;
    b_in = use_imm_q ? {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q} : b_sh;
    sum  = a_in + b_in;
    diff = a_in - b_in;
    c_d  = alu_op_q == ALU_ADD ? sum : alu_op_q == ALU_SUB ? diff :
           alu_op_q == ALU_AND ? (a_in & b_in) : ~b_in;
    v_d  = alu_op_q == ALU_ADD ? (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]) :
           alu_op_q == ALU_SUB ? (a_in[WIDTH-1] != b_in[WIDTH-1]) && (diff[WIDTH-1] != a_in[WIDTH-1]) : 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      {rd_q, rn_q, rm_q, shift_q, alu_op_q, a_zero_q, use_imm_q, cmp_q, imm_q} <= '0;
      {a_q, b_q, c_q, z_q, n_q, v_q, ext_done_q} <= '0;
    end else begin
      state_q <= state_d;
      ext_done_q <= idle && ext_we;
      if (idle) {rd_q, rn_q, rm_q, shift_q, alu_op_q, a_zero_q, use_imm_q, cmp_q, imm_q} <=
                {rd, rn, rm, shift, alu_op, a_zero, use_imm, cmp, imm};
      if (state_q == S_LD_A) a_q <= rdata_a;
      if (state_q == S_LD_B) b_q <= rdata_b;
      if (state_q == S_EXEC) {c_q, z_q, n_q, v_q} <= {c_d, c_d == '0, c_d[WIDTH-1], v_d};
    end
  end
  assign result = c_q;
  assign z = z_q;
  assign n = n_q;
  assign v = v_q;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed table-driven checks of datapath_seq plus multi-cycle corner sequences.
// Two extra instances (8-bit/4-reg/3-bit imm and 32-bit/16-reg) share the stimulus for the width sweep.
module tb_datapath_seq;
  typedef struct {
    logic [2:0]  rd, rn, rm;
    logic [1:0]  sh, op;
    logic        az, ui, cm;
    logic [4:0]  imm;
    logic [15:0] res;
    logic [2:0]  f;
    logic [15:0] rval;
  } vec_t;
  logic clk = 0, reset = 1;
  logic start = 0, ext_we = 0, a_zero = 0, use_imm = 0, cmp = 0;
  logic [3:0] rd = 0, rn = 0, rm = 0;
  logic [1:0] shift = 0, alu_op = 0;
  logic [4:0] imm = 0;
  logic [31:0] ext_in = 0;
  logic busy, done, z, n, v, busy8, done8, z8, n8, v8, busy32, done32, z32, n32, v32;
  logic [15:0] result;
  logic [7:0] result8;
  logic [31:0] result32;
  int checks = 0, failures = 0;
  vec_t tbl[11];
  always #5 clk = ~clk;
  datapath_seq dut (
    .clk(clk), .reset(reset), .start(start), .ext_we(ext_we), .rd(rd[2:0]), .rn(rn[2:0]), .rm(rm[2:0]),
    .shift(shift), .alu_op(alu_op), .a_zero(a_zero), .use_imm(use_imm), .cmp(cmp), .imm(imm),
    .ext_in(ext_in[15:0]), .busy(busy), .done(done), .result(result), .z(z), .n(n), .v(v)
  );
  datapath_seq #(.WIDTH(8), .NREGS(4), .IMM_W(3)) dut8 (
    .clk(clk), .reset(reset), .start(start), .ext_we(ext_we), .rd(rd[1:0]), .rn(rn[1:0]), .rm(rm[1:0]),
    .shift(shift), .alu_op(alu_op), .a_zero(a_zero), .use_imm(use_imm), .cmp(cmp), .imm(imm[2:0]),
    .ext_in(ext_in[7:0]), .busy(busy8), .done(done8), .result(result8), .z(z8), .n(n8), .v(v8)
  );
  datapath_seq #(.WIDTH(32), .NREGS(16)) dut32 (
    .clk(clk), .reset(reset), .start(start), .ext_we(ext_we), .rd(rd), .rn(rn), .rm(rm),
    .shift(shift), .alu_op(alu_op), .a_zero(a_zero), .use_imm(use_imm), .cmp(cmp), .imm(imm),
    .ext_in(ext_in), .busy(busy32), .done(done32), .result(result32), .z(z32), .n(n32), .v(v32)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic ext_wr(input logic [3:0] d, input logic [31:0] data);
    rd = d; ext_in = data; ext_we = 1;
    tick;
    ext_we = 0;
    tick;
  endtask
  task automatic set_op(input logic [3:0] d, a, b, input logic [1:0] sh, op, input logic az, ui, cm,
                        input logic [4:0] im);
    rd = d; rn = a; rm = b; shift = sh; alu_op = op; a_zero = az; use_imm = ui; cmp = cm; imm = im;
  endtask
  // pulse start and return the number of cycles until done (bounded)
  task automatic go(output int lat);
    start = 1;
    tick;
    start = 0;
    lat = 1;
    while (!done && lat < 10) begin
      tick;
      lat++;
    end
  endtask
  task automatic run_vec(input vec_t t, input int idx);
    int lat;
    set_op({1'b0, t.rd}, {1'b0, t.rn}, {1'b0, t.rm}, t.sh, t.op, t.az, t.ui, t.cm, t.imm);
    go(lat);
    chk($sformatf("v%0d_latency", idx), lat, 4);
    chk($sformatf("v%0d_result", idx), result, t.res);
    chk($sformatf("v%0d_flags_znv", idx), {z, n, v}, t.f);
    tick;
    chk($sformatf("v%0d_reg", idx), dut.u_rf.mem_q[t.rd], t.rval);
    chk($sformatf("v%0d_idle", idx), {busy, done}, 2'b00);
  endtask
  initial begin
    int lat, pulses, bsy;
    vec_t t;
    tbl[0]  = '{3'd2, 3'd3, 3'd3, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 5'h00, 16'h0015, 3'b000, 16'h0015};
    tbl[1]  = '{3'd5, 3'd1, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 5'h00, 16'h7FFF, 3'b001, 16'h7FFF};
    tbl[2]  = '{3'd2, 3'd3, 3'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 5'h00, 16'h0000, 3'b100, 16'h0015};
    tbl[3]  = '{3'd7, 3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 5'h1F, 16'hFFFF, 3'b010, 16'hFFFF};
    tbl[4]  = '{3'd5, 3'd0, 3'd4, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 5'h00, 16'hC001, 3'b010, 16'hC001};
    tbl[5]  = '{3'd6, 3'd4, 3'd7, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 5'h00, 16'h8002, 3'b010, 16'h8002};
    tbl[6]  = '{3'd6, 3'd0, 3'd0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 5'h00, 16'hFFFF, 3'b010, 16'hFFFF};
    tbl[7]  = '{3'd6, 3'd1, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000, 3'b101, 16'h0000};
    tbl[8]  = '{3'd6, 3'd1, 3'd4, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 5'h00, 16'h3FFF, 3'b001, 16'h3FFF};
    tbl[9]  = '{3'd3, 3'd3, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'h00, 16'h000E, 3'b000, 16'h000E};
    tbl[10] = '{3'd6, 3'd3, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 5'h0A, 16'h0018, 3'b000, 16'h0018};
    tick;
    tick;
    chk("rst_outputs", {busy, done, z, n, v}, 5'b0);
    chk("rst_result", result, 16'h0);
    reset = 0;
    tick;
    chk("post_rst_outputs", {busy, done, z, n, v}, 5'b0);
    rd = 3; ext_in = 32'h0007; ext_we = 1;
    tick;
    ext_we = 0;
    chk("ext_done", {busy, done}, 2'b01);
    tick;
    chk("ext_done_clear", {busy, done}, 2'b00);
    chk("ext_r3", dut.u_rf.mem_q[3], 16'h0007);
    ext_wr(0, 32'h0001);
    ext_wr(1, 32'h8000);
    ext_wr(4, 32'h8002);
    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);
    // start held through the whole op while inputs and ext_we change under it
    set_op(3, 3, 0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'h0);
    start = 1;
    tick;
    rd = 4; rm = 4; ext_we = 1; ext_in = 32'h1234;
    lat = 1;
    while (!done && lat < 10) begin
      tick;
      lat++;
    end
    chk("hold_latency", lat, 4);
    chk("hold_result", result, 16'h000F);
    start = 0; ext_we = 0; pulses = 0; bsy = 0;
    repeat (3) begin
      tick;
      pulses += int'(done);
      bsy += int'(busy);
    end
    chk("hold_extra_done", pulses, 0);
    chk("hold_extra_busy", bsy, 0);
    chk("hold_r3", dut.u_rf.mem_q[3], 16'h000F);
    chk("hold_r4_untouched", dut.u_rf.mem_q[4], 16'h8002);
    set_op(5, 3, 3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'h0);
    ext_in = 32'h00AA; ext_we = 1; start = 1;
    tick;
    ext_we = 0; start = 0;
    chk("both_done", {busy, done}, 2'b01);
    tick;
    chk("both_no_op", {busy, done}, 2'b00);
    tick;
    chk("both_still_idle", busy, 1'b0);
    chk("both_r5", dut.u_rf.mem_q[5], 16'h00AA);
    chk("both_flags_held", {z, n, v}, 3'b000);
    t = '{3'd7, 3'd0, 3'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 5'h00, 16'hFFFE, 3'b010, 16'hFFFE};
    run_vec(t, 11);
    set_op(2, 3, 3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'h0);
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    chk("pre_abort_busy", busy, 1'b1);
    #2 reset = 1;
    #1;
    chk("abort_outputs", {busy, done, z, n, v}, 5'b0);
    chk("abort_result", result, 16'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("abort_r%0d", i), dut.u_rf.mem_q[i], 16'h0);
    tick;
    reset = 0;
    pulses = 0;
    repeat (6) begin
      tick;
      pulses += int'(done);
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_r2", dut.u_rf.mem_q[2], 16'h0);
    ext_wr(1, 32'h7F);
    ext_wr(2, 32'h01);
    set_op(3, 1, 2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'h0);
    go(lat);
    chk("w8_add_done", {done8, lat[3:0]}, 5'h14);
    chk("w8_add_result", result8, 8'h80);
    chk("w8_add_flags", {z8, n8, v8}, 3'b011);
    tick;
    ext_wr(1, 32'h80);
    set_op(3, 1, 2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 5'h0);
    go(lat);
    chk("w8_sub_result", result8, 8'h7F);
    chk("w8_sub_flags", {z8, n8, v8}, 3'b001);
    tick;
    ext_wr(1, 32'h7FFF_FFFF);
    ext_wr(2, 32'h1);
    set_op(15, 1, 2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'h0);
    go(lat);
    chk("w32_add_done", {done32, lat[3:0]}, 5'h14);
    chk("w32_add_result", result32, 32'h8000_0000);
    chk("w32_add_flags", {z32, n32, v32}, 3'b011);
    tick;
    set_op(14, 15, 2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 5'h0);
    go(lat);
    chk("w32_sub_result", result32, 32'h7FFF_FFFF);
    chk("w32_sub_flags", {z32, n32, v32}, 3'b001);
    tick;
    chk("sweep_idle", {busy8, busy32}, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
